// File: rtl/intc_if.sv
// -----------------------------------------------------------------------------
// intc_if -- CPU data-bus view of the interrupt controller register block.
//   addr   : byte address presented by the CPU (M stage)
//   wdata  : write data
//   byteen : byte enables, nonzero means a write cycle
//   rdata  : combinational read data returned for addr
// master modport = CPU side, slave modport = intc side.
// -----------------------------------------------------------------------------
interface intc_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output byteen, input rdata);
  modport slave  (input addr, input wdata, input byteen, output rdata);
endinterface

// File: rtl/intc.sv
// -----------------------------------------------------------------------------
// intc -- edge-detecting interrupt controller with ACK/MASK/PEND registers.
//
// Ports:
//   clk              : system clock, rising edge
//   reset            : synchronous, active-high reset
//   bus              : intc_if.slave CPU register port (addr/wdata/byteen/rdata)
//   src_i[5:0]       : raw interrupt sources, bit i -> hwint_o[i]
//   macroscopic_pc_i : committed PC, only looked at by the PC trigger
//   hwint_o[5:0]     : registered pend & mask, to CP0
//   irq_o            : registered OR of pend & mask
//
// Register map (word decoded, addr & ~3):
//   0x7F20 ACK  write-1-to-clear pend, reads 0
//   0x7F24 MASK RW bits[5:0], resets to 6'h3F
//   0x7F28 PEND RO bits[5:0]
//   0x7F2C TRIG_PC (only with INTC_PC_TRIG_EN; reads 0 otherwise)
// Only full-word writes (byteen == 4'b1111) modify state.
//
// Build option: define INTC_PC_TRIG_EN to add a one-shot PC trigger that
// raises pend[2] when the committed PC matches the armed TRIG_PC value.
// -----------------------------------------------------------------------------
module intc (
  input  logic        clk,
  input  logic        reset,
  intc_if.slave       bus,
  input  logic [5:0]  src_i,
  input  logic [31:0] macroscopic_pc_i,
  output logic [5:0]  hwint_o,
  output logic        irq_o
);

  localparam logic [31:0] ADDR_ACK  = 32'h0000_7F20;
  localparam logic [31:0] ADDR_MASK = 32'h0000_7F24;
  localparam logic [31:0] ADDR_PEND = 32'h0000_7F28;
  localparam logic [31:0] ADDR_TRIG = 32'h0000_7F2C;

  logic [5:0]  src_q, pend_q, mask_q, hwint_q;
  logic        irq_q;
  logic [5:0]  pend_d, mask_d, hwint_d;
  logic        irq_d;

  logic [31:0] word_addr_s;
  logic        wr_full_s;
  logic        ack_we_s;
  logic        mask_we_s;
  logic [5:0]  ack_clr_s;
  logic [5:0]  set_s;
  logic [31:0] trig_rd_s;

  assign word_addr_s = bus.addr & 32'hFFFF_FFFC;
  assign wr_full_s   = (bus.byteen == 4'b1111);
  assign ack_we_s    = wr_full_s && (word_addr_s == ADDR_ACK);
  assign mask_we_s   = wr_full_s && (word_addr_s == ADDR_MASK);

`ifdef INTC_PC_TRIG_EN
  logic [31:0] trig_pc_q, trig_pc_d;
  logic        armed_q, armed_d;
  logic        trig_we_s;
  logic        trig_hit_s;

  assign trig_we_s  = wr_full_s && (word_addr_s == ADDR_TRIG);
  // Match uses the pre-edge armed/trig_pc, so it fires at most once per arm.
  assign trig_hit_s = armed_q && ((macroscopic_pc_i & 32'hFFFF_FFFC) == trig_pc_q);
  assign set_s      = (src_i & ~src_q) | {3'b000, trig_hit_s, 2'b00};
  assign trig_rd_s  = {trig_pc_q[31:2], 1'b0, armed_q};

  // Trigger next state: a new write re-arms and takes priority over a hit.
  always_comb begin
    trig_pc_d = trig_pc_q;
    armed_d   = armed_q;
    if (trig_we_s) begin
      trig_pc_d = bus.wdata & 32'hFFFF_FFFC;
      armed_d   = 1'b1;
    end else if (trig_hit_s) begin
      armed_d   = 1'b0;
    end else begin
      armed_d   = armed_q;
    end
  end

  // Trigger state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_pc_q <= 32'h0000_0000;
      armed_q   <= 1'b0;
    end else begin
      trig_pc_q <= trig_pc_d;
      armed_q   <= armed_d;
    end
  end
`else
  logic unused_inputs_s;

  assign set_s           = src_i & ~src_q;
  assign trig_rd_s       = 32'h0000_0000;
  assign unused_inputs_s = ^{macroscopic_pc_i, bus.wdata[31:6]};
`endif

  assign ack_clr_s = ack_we_s ? bus.wdata[5:0] : 6'h00;

  // Next-state logic; set is OR'ed after the clear so a same-edge set wins.
  always_comb begin
    pend_d  = (pend_q & ~ack_clr_s) | set_s;
    mask_d  = mask_we_s ? bus.wdata[5:0] : mask_q;
    // Outputs follow the already-registered pend/mask, one cycle behind them.
    hwint_d = pend_q & mask_q;
    irq_d   = |(pend_q & mask_q);
  end

  // Core state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q   <= 6'h00;
      pend_q  <= 6'h00;
      mask_q  <= 6'h3F;
      hwint_q <= 6'h00;
      irq_q   <= 1'b0;
    end else begin
      src_q   <= src_i;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      hwint_q <= hwint_d;
      irq_q   <= irq_d;
    end
  end

  // Combinational read mux; unmapped words and ACK read as zero.
  always_comb begin
    case (word_addr_s)
      ADDR_ACK:  bus.rdata = 32'h0000_0000;
      ADDR_MASK: bus.rdata = {26'h000_0000, mask_q};
      ADDR_PEND: bus.rdata = {26'h000_0000, pend_q};
      ADDR_TRIG: bus.rdata = trig_rd_s;
      default:   bus.rdata = 32'h0000_0000;
    endcase
  end

  assign hwint_o = hwint_q;
  assign irq_o   = irq_q;

endmodule
